// File: rtl/ctrl_pipe.sv
// Pipelined MIPS control unit: decodes op/funct in D and carries the control
// word through the E, M and W pipeline registers, with stall, flush and illegal-op counting.
module ctrl_pipe #(
    parameter int unsigned ALUCTRL_W = 3,
    parameter bit          EXT       = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 en,
    input  logic                 flushE,
    output logic                 branchD,
    output logic                 bneD,
    output logic                 jumpD,
    output logic                 zeroextD,
    output logic                 regwriteE,
    output logic                 memtoregE,
    output logic                 memwriteE,
    output logic                 alusrcE,
    output logic                 regdstE,
    output logic [ALUCTRL_W-1:0] alucontrolE,
    output logic                 illegalE,
    output logic                 regwriteM,
    output logic                 memtoregM,
    output logic                 memwriteM,
    output logic                 regwriteW,
    output logic                 memtoregW,
    output logic [CNT_W-1:0]     illegal_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                 regwrite;
        logic                 memtoreg;
        logic                 memwrite;
        logic                 alusrc;
        logic                 regdst;
        logic [ALUCTRL_W-1:0] alucontrol;
        logic                 illegal;
    } e_word_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } m_word_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } w_word_t;

    e_word_t          dec_word;
    logic [2:0]       dec_alu;
    logic             dec_branch;
    logic             dec_bne;
    logic             dec_jump;
    logic             dec_zeroext;
    logic             dec_illegal;

    e_word_t          e_d, e_q;
    m_word_t          m_d, m_q;
    w_word_t          w_d, w_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        dec_word    = '0;
        dec_alu     = ALU_AND;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        dec_jump    = 1'b0;
        dec_zeroext = 1'b0;
        dec_illegal = 1'b0;

        case (op)
            OP_RTYPE: begin
                dec_word.regwrite = 1'b1;
                dec_word.regdst   = 1'b1;
                case (funct)
                    FN_ADD:  dec_alu = ALU_ADD;
                    FN_SUB:  dec_alu = ALU_SUB;
                    FN_AND:  dec_alu = ALU_AND;
                    FN_OR:   dec_alu = ALU_OR;
                    FN_SLT:  dec_alu = ALU_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                dec_word.regwrite = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_word.memtoreg = 1'b1;
                dec_alu           = ALU_ADD;
            end
            OP_SW: begin
                dec_word.alusrc   = 1'b1;
                dec_word.memwrite = 1'b1;
                dec_alu           = ALU_ADD;
            end
            OP_BEQ: begin
                dec_branch = 1'b1;
                dec_alu    = ALU_SUB;
            end
            OP_J: dec_jump = 1'b1;
            OP_ADDI: begin
                dec_word.regwrite = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_alu           = ALU_ADD;
                dec_illegal       = !EXT;
            end
            OP_ANDI: begin
                dec_word.regwrite = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_zeroext       = 1'b1;
                dec_alu           = ALU_AND;
                dec_illegal       = !EXT;
            end
            OP_ORI: begin
                dec_word.regwrite = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_zeroext       = 1'b1;
                dec_alu           = ALU_OR;
                dec_illegal       = !EXT;
            end
            OP_SLTI: begin
                dec_word.regwrite = 1'b1;
                dec_word.alusrc   = 1'b1;
                dec_alu           = ALU_SLT;
                dec_illegal       = !EXT;
            end
            OP_BNE: begin
                dec_branch  = 1'b1;
                dec_bne     = 1'b1;
                dec_alu     = ALU_SUB;
                dec_illegal = !EXT;
            end
            default: dec_illegal = 1'b1;
        endcase

        dec_word.alucontrol = ALUCTRL_W'(dec_alu);

        // An undecodable op must never leak enables into the pipeline.
        if (dec_illegal) begin
            dec_word         = '0;
            dec_word.illegal = 1'b1;
            dec_branch       = 1'b0;
            dec_bne          = 1'b0;
            dec_jump         = 1'b0;
            dec_zeroext      = 1'b0;
        end
    end

    always_comb begin
        e_d   = e_q;
        m_d   = m_q;
        w_d   = w_q;
        cnt_d = cnt_q;
        if (en) begin
            e_d = flushE ? e_word_t'('0) : dec_word;
            m_d = '{regwrite: e_q.regwrite, memtoreg: e_q.memtoreg, memwrite: e_q.memwrite};
            w_d = '{regwrite: m_q.regwrite, memtoreg: m_q.memtoreg};
            // A bubble replaces the illegal op, so it is not counted.
            if (!flushE && dec_illegal && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign branchD     = dec_branch;
    assign bneD        = dec_bne;
    assign jumpD       = dec_jump;
    assign zeroextD    = dec_zeroext;

    assign regwriteE   = e_q.regwrite;
    assign memtoregE   = e_q.memtoreg;
    assign memwriteE   = e_q.memwrite;
    assign alusrcE     = e_q.alusrc;
    assign regdstE     = e_q.regdst;
    assign alucontrolE = e_q.alucontrol;
    assign illegalE    = e_q.illegal;

    assign regwriteM   = m_q.regwrite;
    assign memtoregM   = m_q.memtoreg;
    assign memwriteM   = m_q.memwrite;

    assign regwriteW   = w_q.regwrite;
    assign memtoregW   = w_q.memtoreg;

    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: default build, an EXT=0 build with 4-bit ALU
// control, and a CNT_W=2 build, all driven from the same stimulus.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       en;
    logic       flushE;

    int checks   = 0;
    int failures = 0;

    // Default instance (EXT=1, ALUCTRL_W=3, CNT_W=8)
    logic       a_branchD, a_bneD, a_jumpD, a_zeroextD;
    logic       a_regwriteE, a_memtoregE, a_memwriteE, a_alusrcE, a_regdstE, a_illegalE;
    logic [2:0] a_alucontrolE;
    logic       a_regwriteM, a_memtoregM, a_memwriteM, a_regwriteW, a_memtoregW;
    logic [7:0] a_cnt;

    // EXT=0, ALUCTRL_W=4 instance
    logic       b_branchD, b_bneD, b_jumpD, b_zeroextD;
    logic       b_regwriteE, b_memtoregE, b_memwriteE, b_alusrcE, b_regdstE, b_illegalE;
    logic [3:0] b_alucontrolE;
    logic       b_regwriteM, b_memtoregM, b_memwriteM, b_regwriteW, b_memtoregW;
    logic [7:0] b_cnt;

    // CNT_W=2 instance
    logic       c_branchD, c_bneD, c_jumpD, c_zeroextD;
    logic       c_regwriteE, c_memtoregE, c_memwriteE, c_alusrcE, c_regdstE, c_illegalE;
    logic [2:0] c_alucontrolE;
    logic       c_regwriteM, c_memtoregM, c_memwriteM, c_regwriteW, c_memtoregW;
    logic [1:0] c_cnt;

    ctrl_pipe dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .en(en), .flushE(flushE),
        .branchD(a_branchD), .bneD(a_bneD), .jumpD(a_jumpD), .zeroextD(a_zeroextD),
        .regwriteE(a_regwriteE), .memtoregE(a_memtoregE), .memwriteE(a_memwriteE),
        .alusrcE(a_alusrcE), .regdstE(a_regdstE), .alucontrolE(a_alucontrolE),
        .illegalE(a_illegalE), .regwriteM(a_regwriteM), .memtoregM(a_memtoregM),
        .memwriteM(a_memwriteM), .regwriteW(a_regwriteW), .memtoregW(a_memtoregW),
        .illegal_cnt(a_cnt)
    );

    ctrl_pipe #(.ALUCTRL_W(4), .EXT(1'b0), .CNT_W(8)) dut_noext (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .en(en), .flushE(flushE),
        .branchD(b_branchD), .bneD(b_bneD), .jumpD(b_jumpD), .zeroextD(b_zeroextD),
        .regwriteE(b_regwriteE), .memtoregE(b_memtoregE), .memwriteE(b_memwriteE),
        .alusrcE(b_alusrcE), .regdstE(b_regdstE), .alucontrolE(b_alucontrolE),
        .illegalE(b_illegalE), .regwriteM(b_regwriteM), .memtoregM(b_memtoregM),
        .memwriteM(b_memwriteM), .regwriteW(b_regwriteW), .memtoregW(b_memtoregW),
        .illegal_cnt(b_cnt)
    );

    ctrl_pipe #(.ALUCTRL_W(3), .EXT(1'b1), .CNT_W(2)) dut_cnt2 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .en(en), .flushE(flushE),
        .branchD(c_branchD), .bneD(c_bneD), .jumpD(c_jumpD), .zeroextD(c_zeroextD),
        .regwriteE(c_regwriteE), .memtoregE(c_memtoregE), .memwriteE(c_memwriteE),
        .alusrcE(c_alusrcE), .regdstE(c_regdstE), .alucontrolE(c_alucontrolE),
        .illegalE(c_illegalE), .regwriteM(c_regwriteM), .memtoregM(c_memtoregM),
        .memwriteM(c_memwriteM), .regwriteW(c_regwriteW), .memtoregW(c_memtoregW),
        .illegal_cnt(c_cnt)
    );

    always #5 clk = ~clk;

    // E word packed as {regwrite, memtoreg, memwrite, alusrc, regdst, illegal}
    wire [5:0] a_e = {a_regwriteE, a_memtoregE, a_memwriteE, a_alusrcE, a_regdstE, a_illegalE};
    wire [5:0] b_e = {b_regwriteE, b_memtoregE, b_memwriteE, b_alusrcE, b_regdstE, b_illegalE};
    wire [5:0] c_e = {c_regwriteE, c_memtoregE, c_memwriteE, c_alusrcE, c_regdstE, c_illegalE};
    wire [2:0] a_m = {a_regwriteM, a_memtoregM, a_memwriteM};
    wire [1:0] a_w = {a_regwriteW, a_memtoregW};
    wire [3:0] a_dd = {a_branchD, a_bneD, a_jumpD, a_zeroextD};
    wire [3:0] b_dd = {b_branchD, b_bneD, b_jumpD, b_zeroextD};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        flushE  = 1'b0;
        op      = 6'b000000;
        funct   = 6'b100000;
        tick();
        tick();
        check("reset_e_word", {26'd0, a_e}, 32'd0);
        check("reset_cnt", {24'd0, a_cnt}, 32'd0);
        reset_n = 1'b1;
        en      = 1'b1;

        // lw -> sw -> add
        op = 6'b100011;
        #1 check("lw_d_outputs", {28'd0, a_dd}, 32'd0);
        tick();
        check("lw_e_word", {26'd0, a_e}, 32'b110100);
        check("lw_e_alu", {29'd0, a_alucontrolE}, 32'b010);
        check("lw_e_alu_w4", {28'd0, b_alucontrolE}, 32'b0010);
        op = 6'b101011;
        tick();
        check("sw_e_word", {26'd0, a_e}, 32'b001100);
        check("lw_m_word", {29'd0, a_m}, 32'b110);
        op = 6'b000000; funct = 6'b100000;
        tick();
        check("add_e_word", {26'd0, a_e}, 32'b100010);
        check("add_e_alu", {29'd0, a_alucontrolE}, 32'b010);
        check("sw_m_word", {29'd0, a_m}, 32'b001);
        check("lw_w_word", {30'd0, a_w}, 32'b11);

        // Extended decode: andi, bne, then R slt and an undefined funct
        op = 6'b001100;
        #1 check("andi_d_ext1", {28'd0, a_dd}, 32'b0001);
        check("andi_d_ext0", {28'd0, b_dd}, 32'b0000);
        tick();
        check("andi_e_word", {26'd0, a_e}, 32'b100100);
        check("andi_e_alu", {29'd0, a_alucontrolE}, 32'b000);
        check("andi_ext0_e_word", {26'd0, b_e}, 32'b000001);
        check("andi_ext0_e_alu", {28'd0, b_alucontrolE}, 32'd0);
        op = 6'b000101;
        #1 check("bne_d_ext1", {28'd0, a_dd}, 32'b1100);
        check("bne_d_ext0", {28'd0, b_dd}, 32'b0000);
        tick();
        check("bne_e_word", {26'd0, a_e}, 32'b000000);
        check("bne_e_alu", {29'd0, a_alucontrolE}, 32'b110);
        check("bne_ext0_e_word", {26'd0, b_e}, 32'b000001);
        op = 6'b000000; funct = 6'b101010;
        tick();
        check("slt_e_alu", {29'd0, a_alucontrolE}, 32'b111);
        check("slt_e_word", {26'd0, a_e}, 32'b100010);
        funct = 6'b000000;
        tick();
        check("rbad_e_word", {26'd0, a_e}, 32'b000001);
        check("rbad_e_alu", {29'd0, a_alucontrolE}, 32'd0);

        // Stall with flush pending: E holds lw, then flushes on the next en=1 edge
        op = 6'b100011; funct = 6'b100000;
        tick();
        check("stall_pre_e_word", {26'd0, a_e}, 32'b110100);
        en = 1'b0; flushE = 1'b1; op = 6'b101011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_hold_e_%0d", i), {26'd0, a_e}, 32'b110100);
        end
        check("stall_hold_m", {29'd0, a_m}, 32'b000);
        en = 1'b1;
        tick();
        check("flush_e_word", {26'd0, a_e}, 32'd0);
        check("flush_m_lw", {29'd0, a_m}, 32'b110);
        flushE = 1'b0;
        tick();
        check("bubble_m_word", {29'd0, a_m}, 32'b000);
        check("bubble_w_lw", {30'd0, a_w}, 32'b11);
        check("post_flush_e_sw", {26'd0, a_e}, 32'b001100);

        // Flush takes priority over an illegal decode
        op = 6'b111111; flushE = 1'b1;
        tick();
        check("flush_illegal_e", {26'd0, a_e}, 32'd0);
        check("flush_illegal_cnt", {24'd0, a_cnt}, 32'd1);
        check("flush_illegal_cnt_ext0", {24'd0, b_cnt}, 32'd3);
        flushE = 1'b0;

        // Asynchronous reset with an add in flight
        op = 6'b000000; funct = 6'b100000;
        tick();
        tick();
        check("inflight_e_add", {26'd0, a_e}, 32'b100010);
        check("inflight_m_add", {29'd0, a_m}, 32'b100);
        reset_n = 1'b0;
        #1;
        check("async_reset_e", {26'd0, a_e}, 32'd0);
        check("async_reset_m", {29'd0, a_m}, 32'd0);
        check("async_reset_w", {30'd0, a_w}, 32'd0);
        check("async_reset_cnt", {24'd0, a_cnt}, 32'd0);
        check("async_reset_alu", {29'd0, a_alucontrolE}, 32'd0);
        #1 reset_n = 1'b1;

        // Saturating counter: CNT_W=2 saturates at 3, CNT_W=8 keeps counting
        op = 6'b111111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("cnt2_step_%0d", i), {30'd0, c_cnt}, (i < 3) ? i + 1 : 3);
            check($sformatf("cnt2_e_word_%0d", i), {26'd0, c_e}, 32'b000001);
            check($sformatf("cnt8_step_%0d", i), {24'd0, a_cnt}, i + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
